// File: rtl/config_chain_pkg.sv
// Shared definitions for the tile configuration chain loader:
// controller states and word-count helper.
package config_chain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

  function automatic int words_for_chain(input int chain_length, input int word_width);
    return (chain_length + word_width - 1) / word_width;
  endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// Host-side stream of the configuration loader: bitstream words in,
// displaced chain contents back out as readback words.
interface config_chain_loader_if #(
  parameter int WORD_WIDTH = 8
) ();

  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;
  logic [WORD_WIDTH-1:0] readback_data;
  logic                  readback_valid;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready,
    input  readback_data,
    input  readback_valid
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready,
    output readback_data,
    output readback_valid
  );

endinterface

// File: rtl/config_readback_deserializer.sv
// Collects the bits falling out of the end of the chain into readback words,
// LSB first, strobing each full word and the zero-padded final partial word.
module config_readback_deserializer #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  config_nreset,
  input  logic                  clear,
  input  logic                  sample_enable,
  input  logic                  sample_bit,
  input  logic                  last_bit,
  output logic [WORD_WIDTH-1:0] readback_data,
  output logic                  readback_valid
);

  localparam int CNT_W = $clog2(WORD_WIDTH + 1);

  logic [WORD_WIDTH-1:0] sample_reg;
  logic [CNT_W-1:0]      sample_cnt;
  logic [WORD_WIDTH-1:0] merged;
  logic                  word_full;

  always_comb begin
    merged    = sample_reg | (WORD_WIDTH'(sample_bit) << sample_cnt);
    word_full = (sample_cnt == CNT_W'(WORD_WIDTH - 1));
  end

  // The assembly register is cleared after every strobe so a short final word
  // comes out with zeros in its unused high bits.
  always_ff @(posedge clock or negedge config_nreset) begin
    if (!config_nreset) begin
      sample_reg     <= '0;
      sample_cnt     <= '0;
      readback_data  <= '0;
      readback_valid <= 1'b0;
    end else begin
      readback_valid <= 1'b0;
      if (clear) begin
        sample_reg <= '0;
        sample_cnt <= '0;
      end else if (sample_enable) begin
        if (word_full || last_bit) begin
          readback_data  <= merged;
          readback_valid <= 1'b1;
          sample_reg     <= '0;
          sample_cnt     <= '0;
        end else begin
          sample_reg <= merged;
          sample_cnt <= sample_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/config_chain_loader.sv
// Writer side of the tile configuration chain: serializes host words onto the
// chain one bit per cycle while capturing the displaced contents for readback.
module config_chain_loader
  import config_chain_pkg::*;
#(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 1024
) (
  input  logic                  clock,
  input  logic                  config_nreset,
  input  logic                  start,
  input  logic                  abort,
  config_chain_loader_if.slave  host,
  output logic                  chain_config_in,
  output logic                  chain_config_enable,
  input  logic                  chain_config_out,
  output logic                  busy,
  output logic                  done
);

  localparam int COUNT_WIDTH = $clog2(CHAIN_LENGTH + 1);
  localparam int WORD_COUNT  = words_for_chain(CHAIN_LENGTH, WORD_WIDTH);
  localparam int WORD_CNT_W  = $clog2(WORD_COUNT + 1);
  localparam int REM_W       = $clog2(WORD_WIDTH + 1);
  localparam int LAST_K      = CHAIN_LENGTH - (WORD_COUNT - 1) * WORD_WIDTH;

  localparam logic [COUNT_WIDTH-1:0] LAST_BIT  = COUNT_WIDTH'(CHAIN_LENGTH - 1);
  localparam logic [WORD_CNT_W-1:0]  LAST_WORD = WORD_CNT_W'(WORD_COUNT - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]            state;
  logic [COUNT_WIDTH-1:0] bit_cnt;
  logic [WORD_CNT_W-1:0] word_cnt;
  logic [REM_W-1:0]      bits_left;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic                  word_ready_q;
  logic                  final_bit;
  logic                  readback_clear;

  assign host.word_ready = word_ready_q;
  assign final_bit       = (bit_cnt == LAST_BIT);
  assign readback_clear  = abort && busy;

  // Only the last word of the chain is short; every other word shifts all of
  // its bits, so the length is picked from the word index rather than a subtract.
  always_ff @(posedge clock or negedge config_nreset) begin
    if (!config_nreset) begin
      state               <= ST_IDLE;
      bit_cnt             <= '0;
      word_cnt            <= '0;
      bits_left           <= '0;
      shift_reg           <= '0;
      word_ready_q        <= 1'b0;
      chain_config_in     <= 1'b0;
      chain_config_enable <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_FETCH;
            busy         <= 1'b1;
            word_ready_q <= 1'b1;
            bit_cnt      <= '0;
            word_cnt     <= '0;
          end
        end
        ST_FETCH: begin
          if (abort) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            word_ready_q <= 1'b0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            bits_left    <= '0;
          end else if (host.word_valid) begin
            state               <= ST_SHIFT;
            word_ready_q        <= 1'b0;
            shift_reg           <= host.word_data >> 1;
            chain_config_in     <= host.word_data[0];
            chain_config_enable <= 1'b1;
            bits_left           <= (word_cnt == LAST_WORD) ? REM_W'(LAST_K) : REM_W'(WORD_WIDTH);
            word_cnt            <= word_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state               <= ST_IDLE;
            busy                <= 1'b0;
            chain_config_in     <= 1'b0;
            chain_config_enable <= 1'b0;
            bit_cnt             <= '0;
            word_cnt            <= '0;
            bits_left           <= '0;
          end else begin
            bit_cnt   <= bit_cnt + 1'b1;
            bits_left <= bits_left - 1'b1;
            shift_reg <= shift_reg >> 1;
            if (bits_left == REM_W'(1)) begin
              chain_config_in     <= 1'b0;
              chain_config_enable <= 1'b0;
              if (final_bit) begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state        <= ST_FETCH;
                word_ready_q <= 1'b1;
              end
            end else begin
              chain_config_in <= shift_reg[0];
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  config_readback_deserializer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_readback (
    .clock         (clock),
    .config_nreset (config_nreset),
    .clear         (readback_clear),
    .sample_enable (chain_config_enable),
    .sample_bit    (chain_config_out),
    .last_bit      (final_bit),
    .readback_data (host.readback_data),
    .readback_valid(host.readback_valid)
  );

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed self-checking bench for config_chain_loader on a 12-bit chain
// modelled as a plain shift register between config_in and config_out.
module tb_config_chain_loader;

  localparam int WW = 8;
  localparam int CL = 12;

  logic clock = 1'b0;
  logic config_nreset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic chain_config_in;
  logic chain_config_enable;
  logic chain_config_out;
  logic busy;
  logic done;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  config_chain_loader_if #(.WORD_WIDTH(WW)) host_if ();

  config_chain_loader #(
    .WORD_WIDTH  (WW),
    .CHAIN_LENGTH(CL)
  ) dut (
    .clock              (clock),
    .config_nreset      (config_nreset),
    .start              (start),
    .abort              (abort),
    .host               (host_if),
    .chain_config_in    (chain_config_in),
    .chain_config_enable(chain_config_enable),
    .chain_config_out   (chain_config_out),
    .busy               (busy),
    .done               (done)
  );

  // Chain model: the last tile's bit is the MSB, new bits enter at the LSB.
  logic [CL-1:0] chain_q = '0;
  logic [CL-1:0] preload_val = '0;
  logic          preload_req = 1'b0;

  assign chain_config_out = chain_q[CL-1];

  always @(posedge clock) begin
    if (preload_req) chain_q <= preload_val;
    else if (chain_config_enable) chain_q <= {chain_q[CL-2:0], chain_config_in};
  end

  // Monitor sampled mid-cycle on the falling edge.
  logic        clear_mon = 1'b0;
  int          cyc = 0;
  int          en_count = 0;
  int          last_en_cyc = 0;
  int          gap = 0;
  int          done_count = 0;
  int          rb_count = 0;
  logic [15:0] ser_word = '0;
  logic [7:0]  rb_first = '0;
  logic [7:0]  rb_second = '0;
  logic        busy_prev = 1'b0;
  logic        busy_before_done = 1'b0;
  logic        busy_at_done = 1'b0;

  always @(negedge clock) begin
    cyc       <= cyc + 1;
    busy_prev <= busy;
    if (clear_mon) begin
      en_count   <= 0;
      gap        <= 0;
      done_count <= 0;
      rb_count   <= 0;
      ser_word   <= '0;
      rb_first   <= '0;
      rb_second  <= '0;
    end else begin
      if (chain_config_enable) begin
        if (en_count < 16) ser_word[en_count[3:0]] <= chain_config_in;
        if (en_count == 8) gap <= cyc - last_en_cyc;
        last_en_cyc <= cyc;
        en_count    <= en_count + 1;
      end
      if (done) begin
        done_count       <= done_count + 1;
        busy_before_done <= busy_prev;
        busy_at_done     <= busy;
      end
      if (host_if.readback_valid) begin
        if (rb_count == 0) rb_first <= host_if.readback_data;
        else if (rb_count == 1) rb_second <= host_if.readback_data;
        rb_count <= rb_count + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic v, input logic [WW-1:0] d);
    start              = s;
    abort              = a;
    host_if.word_valid = v;
    host_if.word_data  = d;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic preloadChain(input logic [CL-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    tick();
    preload_req = 1'b0;
  endtask

  task automatic clearMonitor();
    clear_mon = 1'b1;
    @(negedge clock);
    #1;
    clear_mon = 1'b0;
  endtask

  task automatic sendWord(input logic [WW-1:0] w, input int stall);
    int guard = 0;
    if (stall > 0) begin
      host_if.word_valid = 1'b0;
      while (!host_if.word_ready && guard < 50) begin
        tick();
        guard++;
      end
      for (int i = 0; i < stall; i++) begin
        checkOutput("stall_enable_low", 32'(chain_config_enable), 32'd0);
        tick();
      end
    end
    host_if.word_data  = w;
    host_if.word_valid = 1'b1;
    guard = 0;
    while (!host_if.word_ready && guard < 50) begin
      tick();
      guard++;
    end
    checkOutput("word_ready_seen", 32'(host_if.word_ready), 32'd1);
    tick();
  endtask

  task automatic checkFullLoad(input string tag);
    checkOutput({tag, "_enable_count"}, 32'(en_count), 32'd12);
    checkOutput({tag, "_serial_bits"}, 32'(ser_word), 32'h03A5);
    checkOutput({tag, "_done_count"}, 32'(done_count), 32'd1);
    checkOutput({tag, "_rb_count"}, 32'(rb_count), 32'd2);
    checkOutput({tag, "_rb_first"}, 32'(rb_first), 32'h0F);
    checkOutput({tag, "_rb_second"}, 32'(rb_second), 32'h0F);
    checkOutput({tag, "_chain_contents"}, 32'(chain_q), 32'hA5C);
  endtask

  initial begin
    host_if.word_valid = 1'b0;
    host_if.word_data  = '0;

    // Reset state
    #12;
    checkOutput("rst_word_ready", 32'(host_if.word_ready), 32'd0);
    checkOutput("rst_config_in", 32'(chain_config_in), 32'd0);
    checkOutput("rst_enable", 32'(chain_config_enable), 32'd0);
    checkOutput("rst_rb_data", 32'(host_if.readback_data), 32'd0);
    checkOutput("rst_rb_valid", 32'(host_if.readback_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    tick();
    config_nreset = 1'b1;
    repeat (3) tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_enable", 32'(chain_config_enable), 32'd0);
    checkOutput("idle_word_ready", 32'(host_if.word_ready), 32'd0);

    // Full load with valid held high
    preloadChain(12'hF0F);
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("full_busy_after_start", 32'(busy), 32'd1);
    sendWord(8'hA5, 0);
    sendWord(8'h03, 0);
    host_if.word_valid = 1'b0;
    repeat (15) tick();
    checkFullLoad("full");
    checkOutput("full_gap", 32'(gap), 32'd2);
    checkOutput("full_busy_before_done", 32'(busy_before_done), 32'd1);
    checkOutput("full_busy_at_done", 32'(busy_at_done), 32'd0);
    checkOutput("full_rb_hold", 32'(host_if.readback_data), 32'h0F);
    checkOutput("full_busy_end", 32'(busy), 32'd0);

    // Host stall between the two words
    preloadChain(12'hF0F);
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    sendWord(8'hA5, 0);
    sendWord(8'h03, 5);
    host_if.word_valid = 1'b0;
    repeat (15) tick();
    checkFullLoad("stall");
    checkOutput("stall_gap", 32'(gap), 32'd7);

    // Abort at bit 3 of the first word, then a clean reload
    preloadChain(12'hF0F);
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    sendWord(8'hA5, 0);
    host_if.word_valid = 1'b0;
    repeat (3) tick();
    checkOutput("abort_enable_before", 32'(chain_config_enable), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkOutput("abort_enable_after", 32'(chain_config_enable), 32'd0);
    checkOutput("abort_busy_after", 32'(busy), 32'd0);
    repeat (10) tick();
    checkOutput("abort_done_count", 32'(done_count), 32'd0);
    checkOutput("abort_rb_count", 32'(rb_count), 32'd0);
    checkOutput("abort_enable_count", 32'(en_count), 32'd4);
    preloadChain(12'hF0F);
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    sendWord(8'hA5, 0);
    sendWord(8'h03, 0);
    host_if.word_valid = 1'b0;
    repeat (15) tick();
    checkFullLoad("reload");

    // Reset asserted at bit 6 of the first word
    preloadChain(12'hF0F);
    clearMonitor();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    sendWord(8'hA5, 0);
    host_if.word_valid = 1'b0;
    repeat (6) tick();
    checkOutput("midrst_enable_before", 32'(chain_config_enable), 32'd1);
    config_nreset = 1'b0;
    #1;
    checkOutput("midrst_enable", 32'(chain_config_enable), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_word_ready", 32'(host_if.word_ready), 32'd0);
    tick();
    tick();
    config_nreset = 1'b1;
    repeat (10) tick();
    checkOutput("midrst_done_count", 32'(done_count), 32'd0);
    checkOutput("midrst_rb_count", 32'(rb_count), 32'd0);
    checkOutput("midrst_enable_count", 32'(en_count), 32'd6);

    // Start with abort in IDLE (start wins), then start again while shifting
    preloadChain(12'hF0F);
    clearMonitor();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("startabort_busy", 32'(busy), 32'd1);
    sendWord(8'hA5, 0);
    host_if.word_valid = 1'b0;
    repeat (2) tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    sendWord(8'h03, 0);
    host_if.word_valid = 1'b0;
    repeat (15) tick();
    checkFullLoad("busy_start");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Writer side of the tile configuration chain: accepts bitstream words from a host over a valid/ready stream and serializes them onto the chain's serial input.
- Asserts the chain's shift enable one bit per cycle.
- Deserializes the displaced old contents from the chain's serial output into readback words.
- Sits between the configuration host interface and the first/last tile of the chain.

Parameters:
- WORD_WIDTH, 8, bits per host word; bit 0 is shifted first.
- CHAIN_LENGTH, 1024, total configuration bits in the chain; need not be a multiple of WORD_WIDTH.
- COUNT_WIDTH (localparam), $clog2(CHAIN_LENGTH+1), width of the bit counter.

Ports:
- clock  input  1  single clock, shared with the tile chain.
- config_nreset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a full chain load.
- abort  input  1  synchronous cancel of a load in progress.
- word_data  input  WORD_WIDTH  bitstream word from the host.
- word_valid  input  1  word_data valid.
- word_ready  output  1  loader accepts a word this cycle.
- chain_config_in  output  1  serial bit to the first tile's config_in.
- chain_config_enable  output  1  shift enable to every tile's config_enable.
- chain_config_out  input  1  serial bit from the last tile's config_out.
- readback_data  output  WORD_WIDTH  word of displaced old chain contents.
- readback_valid  output  1  one-cycle strobe for readback_data; no backpressure.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse after the final bit is shifted.

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0, state is IDLE and counters are cleared. Reset mid-load takes effect immediately, leaves the chain partially loaded and produces no done.
- All outputs are registered.
- States:
  - IDLE: start=1 -> FETCH; busy=1 from the next cycle; bit counter := 0.
  - FETCH: word_ready=1. On word_valid&&word_ready, latch word_data into the shift register, set k = min(WORD_WIDTH, CHAIN_LENGTH - bits_shifted), then go to SHIFT.
  - SHIFT: runs for exactly k cycles. In cycle i (0..k-1), chain_config_enable=1 and chain_config_in = word bit i. After the k-th bit, go to FETCH if bits_shifted < CHAIN_LENGTH, else DONE. Unused high bits of the final partial word are discarded.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Timing: a word accepted at edge T drives bit 0 with enable high in cycle T+1. Minimum per-word cost is WORD_WIDTH+1 cycles; the FETCH cycle between words has enable=0.
- Host stall (word_valid=0 in FETCH): chain_config_enable stays 0 and the chain holds.
- Total enable-high cycles per completed load is exactly CHAIN_LENGTH.
- Readback:
  - On every clock edge where chain_config_enable=1, sample chain_config_out (the pre-shift value) into a readback shift register, filling LSB first.
  - After WORD_WIDTH samples, or after the final chain bit, pulse readback_valid for one cycle in the next cycle with readback_data. A final partial word is zero-padded in the high bits.
  - readback_data holds its value between strobes.
- Boundary cases:
  - start while busy: ignored.
  - abort in FETCH or SHIFT: go to IDLE next cycle; enable=0 from the next cycle; no done; no partial readback strobe; counters cleared.
  - abort and start in the same cycle while IDLE: start wins. While busy: abort wins and start is ignored.
  - word_valid asserted in IDLE, SHIFT or DONE: word_ready=0 and the word is not consumed.

Decomposition:
- Package config_chain_pkg holds:
  - the state enum (IDLE, FETCH, SHIFT, DONE);
  - a function words_for_chain(CHAIN_LENGTH, WORD_WIDTH) = ceil(CHAIN_LENGTH / WORD_WIDTH).
- Sub-module config_readback_deserializer contains the sample shift register, sample counter and strobe logic. It is driven by chain_config_enable, chain_config_out and a last-bit flag.

Test Plan:
- Reset check: hold config_nreset=0 -> all outputs 0. Release with no stimulus -> outputs stay 0, busy=0.
- Full load (CHAIN_LENGTH=12, WORD_WIDTH=8): start, then words 0xA5 and 0x03 with valid held high.
  - chain_config_in on enable cycles is 1,0,1,0,0,1,0,1,1,1,0,0.
  - enable is high for exactly 12 cycles with a one-cycle gap after bit 8.
  - done pulses once; busy is high until done.
- Readback: model the chain as a 12-bit shift register preloaded so the bits emerging from config_out are, in order, 1,1,1,1,0,0,0,0,1,1,1,1 -> readback_valid strobes twice, with 0x0F and then 0x0F (the second zero-padded from 4 bits).
- Stall: hold word_valid low for 5 cycles between the two words -> enable stays low throughout; the serial sequence and readback values are identical to the full-load case.
- Abort: abort at SHIFT bit 3 of the first word -> enable=0 the next cycle, no done, no readback strobe. A following start with 0xA5, 0x03 reproduces the full-load sequence.
- Reset mid-load and start while busy:
  - Assert config_nreset low at bit 6 -> outputs 0 immediately.
  - start pulsed during SHIFT -> no effect; enable count is still 12 and done pulses once.
